// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit arbiter and the serial receiver.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 868;
  localparam int unsigned UART_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while clear_i is low and flags the terminal count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned   CntW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Gated by clear_i so a held-clear counter never reports a tick.
  assign tick_o = !clear_i && (cnt_q == CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// 8N1 UART transmitter shared by N_REQ requesters through a round-robin grant in IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
  localparam int unsigned IdxW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_REQ-1:0]                  req_i,
  input  logic [UART_DATA_BITS*N_REQ-1:0]   data_i,
  output logic [N_REQ-1:0]                  ack_o,
  output logic [IdxW-1:0]                   owner_o,
  output logic                              busy_o,
  output logic                              tx_o
);

  if (N_REQ < 2 || N_REQ > 8) begin : gen_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be in 2..8");
  end

  localparam logic [2:0]      LastBit = 3'(UART_DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic [N_REQ-1:0]          ack_q, ack_d;
  logic [IdxW-1:0]           owner_q, owner_d;
  logic [IdxW-1:0]           ptr_q, ptr_d;

  logic                      tick;
  logic                      baud_clear;
  logic [IdxW:0]             pick;
  logic                      grant_vld;
  logic [IdxW-1:0]           grant_idx;
  logic [UART_DATA_BITS-1:0] data_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : gen_data_arr
    assign data_arr[k] = data_i[UART_DATA_BITS*k +: UART_DATA_BITS];
  end

  // Returns {found, index}: first set bit of req scanning upward from ptr, wrapping at N_REQ.
  function automatic logic [IdxW:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IdxW-1:0]  ptr);
    logic            found;
    logic [IdxW-1:0] win;
    logic [IdxW-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = IdxW'((int'(ptr) + i) % int'(N_REQ));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign pick      = rr_pick(req_i, ptr_q);
  assign grant_vld = pick[IdxW];
  assign grant_idx = pick[IdxW-1:0];

  // Held in clear while idle so every frame starts from a fresh bit period.
  assign baud_clear = (state_q == StIdle);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (baud_clear),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    ack_d     = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          state_d = StStart;
          shift_d = data_arr[grant_idx];
          for (int k = 0; k < int'(N_REQ); k++) begin
            ack_d[k] = (grant_idx == IdxW'(k));
          end
          owner_d = grant_idx;
          ptr_d   = (grant_idx == LastIdx) ? '0 : grant_idx + IdxW'(1);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign owner_o = owner_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmit line among `N_REQ` on-chip requesters using round-robin arbitration. It is the transmit-side companion to the board's serial receiver and runs on the same system clock and baud divisor. The block owns the baud timing, the frame state machine and the shift register. Requesters present a byte and hold a request until acknowledged.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `BAUD_DIV`, 868: clock cycles per serial bit (100 MHz / 115200).
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: bit k high means requester k has a byte pending.
- `data`  in  8*N_REQ: byte for requester k on `data[8k+7:8k]`.
- `ack`  out  N_REQ: one-cycle pulse; bit k means requester k's byte was captured.
- `owner`  out  max(1,$clog2(N_REQ)): index of the requester whose frame is on the line.
- `busy`  out  1: high from the grant cycle until the stop bit ends.
- `tx`  out  1: serial line; idles high.

## Operation
- States are IDLE, START, DATA and STOP, encoded as 2 bits.
- **Reset values:** `tx`=1, `busy`=0, `ack`=0, `owner`=0, state=IDLE. The round-robin pointer resets to 0, so requester 0 has first priority.
- **IDLE, no request:** if `req`==0, stay in IDLE.
- **IDLE, grant:**
  - The winner is the first asserted `req` bit, scanning from pointer `p` upward modulo `N_REQ`.
  - In that cycle, latch the winner's `data` into the shift register, pulse its `ack` bit and load `owner`.
  - Set `p` to winner+1, wrapping to 0 after `N_REQ`-1.
  - Go to START.
- **START:** `tx`=0 for `BAUD_DIV` cycles, then go to DATA.
- **DATA:**
  - Send 8 bits LSB first, each held for `BAUD_DIV` cycles.
  - A 3-bit bit counter goes 0..7; the state leaves DATA after bit 7.
- **STOP:** `tx`=1 for `BAUD_DIV` cycles, then return to IDLE with `busy`=0.
- **Baud counter:**
  - Width is $clog2(`BAUD_DIV`).
  - It is cleared on every grant.
  - It counts 0..`BAUD_DIV`-1 and issues a bit tick on terminal count.
  - It never free-runs in IDLE.
- **Request rules:**
  - A requester holds `req` and stable `data` until it sees `ack`.
  - Dropping `req` before `ack` withdraws the request, with no side effects.
  - `req` re-asserted in the cycle after `ack` is a new request.
- `req` changes while `busy` is high have no effect on the frame in flight. `data` is sampled only on the grant edge.
- **Simultaneous requests:** strict round-robin. With all `req` held high, grants go 0,1,2,…,N-1,0,…
- **Reset mid-frame:**
  - `tx` returns to 1 immediately, without waiting for a clock edge.
  - The partial frame is abandoned and no `ack` is re-issued.
  - The pointer returns to 0.
- Bits of `req` at index ≥ `N_REQ` do not exist. Parameter checks are elaboration-time only.

## Timing
- `ack`, `busy` and `owner` are registered and are valid in the cycle after the grant decision edge.
- `tx` falls on the same edge that raises `ack`.
- A frame lasts exactly 10×`BAUD_DIV` cycles, measured from the `tx` falling edge to the end of the stop bit.
- IDLE lasts exactly 1 cycle between back-to-back frames. Minimum grant-to-grant spacing is 10×`BAUD_DIV`+1 cycles.
- Worst-case wait for a requester with `req` held: (`N_REQ`-1) frames plus the frame in flight.
- Throughput is one byte per 10×`BAUD_DIV`+1 cycles.
- `tx` is driven straight from a flop, with no combinational path from `req` or `data`.

## Structure
- Shared package `uart_pkg`:
  - `BAUD_DIV_DEFAULT` = 868.
  - `UART_DATA_BITS` = 8.
  - Typedef of the 2-bit state enum (IDLE/START/DATA/STOP), shared with the receiver.
- One sub-module, `uart_baud_tick`:
  - Parameter `BAUD_DIV`.
  - Inputs `clk`, `reset`, `clear`; output `tick`.
  - Used here and reusable by the receiver.
- Round-robin selection is a combinational function inside `uart_tx_arbiter`. It is not a separate module.

## Test plan
- **Reset:** hold `reset` for 3 cycles with `req`=4'b1111. Expect `tx`=1, `ack`=0, `busy`=0. After release, the first `ack` is 4'b0001.
- **Single byte, `BAUD_DIV`=16:**
  - Stimulus: `req[2]`=1 with `data[23:16]`=8'hA5.
  - `ack` is 4'b0100 for 1 cycle and `owner`=2.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles.
  - `busy` drops after 160 cycles.
- **Round-robin:** all `req` held high, bytes 8'h10..8'h13. Grants occur in order 0,1,2,3,0, spaced 161 cycles apart.
- **Withdrawal:** `req[1]` pulses for 5 cycles during requester 0's frame. No `ack[1]` is issued, and the next grant goes to the next pending requester.
- **Reset mid-frame:** assert `reset` during data bit 4 of requester 3's frame. `tx`=1 immediately. After release, `req`=4'b1000 gives `ack` 4'b1000 and a full frame is resent.
- **Stable capture:** change `data[7:0]` from 8'h3C to 8'hFF one cycle after `ack[0]`. The line still carries 8'h3C.
